// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - command-level stepper controller driving a signed step-count register
//
// Accepts a signed step command, loads it into an external counter register,
// then issues one coil step per dwell period while counting the register toward zero.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_steps[7:0]          signed step count
//   step_period[DELAY_W]    dwell cycles between steps, 0 behaves as 1
//   abort                   stop the current command
//   reg_load/reg_data       counter load strobe and value
//   reg_increment/decrement counter count strobes
//   reg_negative/positive/zero  registered counter flags (valid two cycles after a strobe)
//   busy, dir, step_pulse   run status, direction, per-step pulse
//   coils[3:0]              full-step coil pattern
//   done, aborted           one-cycle completion pulses
module step_sequencer #(
  parameter int DELAY_W = 16,
  parameter bit HOLD    = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [7:0]         cmd_steps,
  input  logic [DELAY_W-1:0] step_period,
  input  logic               abort,
  output logic               reg_load,
  output logic [7:0]         reg_data,
  output logic               reg_increment,
  output logic               reg_decrement,
  input  logic               reg_negative,
  input  logic               reg_positive,
  input  logic               reg_zero,
  output logic               busy,
  output logic               dir,
  output logic               step_pulse,
  output logic [3:0]         coils,
  output logic               done,
  output logic               aborted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_STEP   = 3'd4;
  localparam logic [2:0] S_DWELL  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [DELAY_W-1:0] ONE = {{(DELAY_W-1){1'b0}}, 1'b1};

  logic [2:0]         state;
  logic [7:0]         cap;
  logic [DELAY_W-1:0] period;
  logic [DELAY_W-1:0] dwell;
  logic [3:0]         phase;
  logic               dir_q;
  logic               energised;
  logic               aborted_q;
  logic               kill;

  // Abort only has effect once a command is in flight.
  assign kill = abort && (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cap       <= 8'h00;
      period    <= ONE;
      dwell     <= '0;
      phase     <= 4'b0001;
      dir_q     <= 1'b1;
      energised <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= 1'b0;
      if (kill) begin
        state     <= S_IDLE;
        aborted_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_valid) begin
              cap       <= cmd_steps;
              period    <= (step_period == '0) ? ONE : step_period;
              energised <= 1'b1;
              state     <= S_LOAD;
            end
          end
          S_LOAD:   state <= S_SETTLE;
          // One idle cycle so the counter flags reflect the load before CHECK.
          S_SETTLE: state <= S_CHECK;
          S_CHECK: begin
            if (reg_zero) begin
              state <= S_DONE;
            end else if (reg_positive) begin
              dir_q <= 1'b1;
              state <= S_STEP;
            end else if (reg_negative) begin
              dir_q <= 1'b0;
              state <= S_STEP;
            end else begin
              // No flag set means the counter is not answering; finish rather than hang.
              state <= S_DONE;
            end
          end
          S_STEP: begin
            phase <= dir_q ? {phase[2:0], phase[3]} : {phase[0], phase[3:1]};
            dwell <= period;
            state <= S_DWELL;
          end
          S_DWELL: begin
            // period >= 1, so DWELL lasts exactly period cycles; the extra
            // CHECK and STEP cycles give a step spacing of period+2.
            if (dwell <= ONE) begin
              state <= S_CHECK;
            end else begin
              dwell <= dwell - ONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign reg_load      = (state == S_LOAD) && !abort;
  assign reg_data      = cap;
  assign step_pulse    = (state == S_STEP) && !abort;
  assign reg_decrement = step_pulse && dir_q;
  assign reg_increment = step_pulse && !dir_q;
  assign done          = (state == S_DONE) && !abort;
  assign aborted       = aborted_q;
  assign dir           = dir_q;
  assign coils         = (busy || (HOLD && energised)) ? phase : 4'b0000;

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - self-checking bench for step_sequencer with HOLD=1 and HOLD=0 instances
module tb_step_sequencer;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          cmd_valid;
  logic          abort;
  logic [7:0]    cmd_steps;
  logic [DW-1:0] step_period;

  logic [1:0] cmd_ready_d, busy_d, reg_load_d, reg_inc_d, reg_dec_d;
  logic [1:0] dir_d, step_d, done_d, aborted_d;
  logic [7:0] reg_data_d [2];
  logic [3:0] coils_d [2];

  logic signed [7:0] cnt [2];
  logic [1:0] zf, pf, nf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  step_sequencer #(.DELAY_W(DW), .HOLD(1'b1)) u_hold (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_d[0]),
    .cmd_steps(cmd_steps), .step_period(step_period), .abort(abort),
    .reg_load(reg_load_d[0]), .reg_data(reg_data_d[0]),
    .reg_increment(reg_inc_d[0]), .reg_decrement(reg_dec_d[0]),
    .reg_negative(nf[0]), .reg_positive(pf[0]), .reg_zero(zf[0]),
    .busy(busy_d[0]), .dir(dir_d[0]), .step_pulse(step_d[0]), .coils(coils_d[0]),
    .done(done_d[0]), .aborted(aborted_d[0])
  );

  step_sequencer #(.DELAY_W(DW), .HOLD(1'b0)) u_nohold (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_d[1]),
    .cmd_steps(cmd_steps), .step_period(step_period), .abort(abort),
    .reg_load(reg_load_d[1]), .reg_data(reg_data_d[1]),
    .reg_increment(reg_inc_d[1]), .reg_decrement(reg_dec_d[1]),
    .reg_negative(nf[1]), .reg_positive(pf[1]), .reg_zero(zf[1]),
    .busy(busy_d[1]), .dir(dir_d[1]), .step_pulse(step_d[1]), .coils(coils_d[1]),
    .done(done_d[1]), .aborted(aborted_d[1])
  );

  // Counter register environment: strobe in cycle P -> value in P+1 -> flags in P+2.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        cnt[i] <= 8'sd0;
        zf[i]  <= 1'b1;
        pf[i]  <= 1'b0;
        nf[i]  <= 1'b0;
      end else begin
        if (reg_load_d[i]) cnt[i] <= reg_data_d[i];
        else if (reg_inc_d[i]) cnt[i] <= cnt[i] + 8'sd1;
        else if (reg_dec_d[i]) cnt[i] <= cnt[i] - 8'sd1;
        zf[i] <= (cnt[i] == 8'sd0);
        pf[i] <= (cnt[i] > 8'sd0);
        nf[i] <= (cnt[i] < 8'sd0);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: a run is described by the cycle offset k since accept.
  // Load at k=1, steps at k = 4 + i*(period+2) for i < |N|, done at 4 + |N|*(period+2).
  bit   m_active, m_fwd, m_dir = 1'b1, m_en, m_abp;
  int   m_k, m_nabs, m_per, m_phase;
  logic [7:0] m_cap;

  function automatic int sval(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sabs(input logic [7:0] v);
    return (sval(v) < 0) ? -sval(v) : sval(v);
  endfunction

  function automatic int done_k();
    return 4 + m_nabs * (m_per + 2);
  endfunction

  function automatic bit step_now();
    return (m_k >= 4) && (((m_k - 4) % (m_per + 2)) == 0) && (((m_k - 4) / (m_per + 2)) < m_nabs);
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_phase  <= 0;
      m_dir    <= 1'b1;
      m_en     <= 1'b0;
      m_abp    <= 1'b0;
      m_cap    <= 8'h00;
    end else if (!m_active) begin
      m_abp <= 1'b0;
      if (cmd_valid) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_cap    <= cmd_steps;
        m_nabs   <= sabs(cmd_steps);
        m_fwd    <= (sval(cmd_steps) > 0);
        m_per    <= (step_period == '0) ? 1 : int'(step_period);
        m_en     <= 1'b1;
      end
    end else if (abort) begin
      m_active <= 1'b0;
      m_abp    <= 1'b1;
    end else begin
      m_abp <= 1'b0;
      if (step_now()) m_phase <= m_fwd ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
      if (m_k == 3 && m_nabs > 0) m_dir <= m_fwd;
      if (m_k == done_k()) m_active <= 1'b0;
      m_k <= m_k + 1;
    end
  end

  // Event log of the HOLD=1 instance, times relative to the accept cycle.
  int t_acc = 0, done_rel = -1, done_cnt = 0, loads = 0;
  int step_log[$];
  int coil_log[$];
  bit prev_step = 1'b0;

  always @(negedge clk) begin
    if (cmd_ready_d[0] === 1'b1 && cmd_valid) t_acc <= cyc;
    if (step_d[0] === 1'b1) step_log.push_back(cyc - t_acc);
    if (prev_step) coil_log.push_back(int'(coils_d[0]));
    if (done_d[0] === 1'b1) begin
      done_rel <= cyc - t_acc;
      done_cnt <= done_cnt + 1;
    end
    if (reg_load_d[0] === 1'b1) loads <= loads + 1;
    prev_step <= (step_d[0] === 1'b1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string nm, input int q[$], input int from, input int e[$]);
    chk({nm, "_count"}, q.size() - from, e.size());
    for (int j = 0; j < e.size(); j++)
      if (from + j < q.size()) chk($sformatf("%s_%0d", nm, j), q[from + j], e[j]);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit   e_step;
        logic [3:0] e_coil;
        e_step = m_active && step_now() && !abort;
        e_coil = (m_active || (i == 0 && m_en)) ? 4'(1 << m_phase) : 4'b0000;
        chk($sformatf("u%0d_cmd_ready", i), cmd_ready_d[i], !m_active);
        chk($sformatf("u%0d_busy", i), busy_d[i], m_active);
        chk($sformatf("u%0d_reg_load", i), reg_load_d[i], m_active && m_k == 1 && !abort);
        chk($sformatf("u%0d_reg_data", i), reg_data_d[i], m_cap);
        chk($sformatf("u%0d_step_pulse", i), step_d[i], e_step);
        chk($sformatf("u%0d_reg_decrement", i), reg_dec_d[i], e_step && m_fwd);
        chk($sformatf("u%0d_reg_increment", i), reg_inc_d[i], e_step && !m_fwd);
        chk($sformatf("u%0d_done", i), done_d[i], m_active && m_k == done_k() && !abort);
        chk($sformatf("u%0d_aborted", i), aborted_d[i], !m_active && m_abp);
        chk($sformatf("u%0d_dir", i), dir_d[i], m_dir);
        chk($sformatf("u%0d_coils", i), coils_d[i], e_coil);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] s, input int p);
    tick();
    cmd_steps   = s;
    step_period = DW'(p);
    cmd_valid   = 1'b1;
    tick();
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_end(input string nm, input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done_d[0] === 1'b1 || aborted_d[0] === 1'b1) break;
      n++;
    end
    #1;
    chk({nm, "_in_budget"}, n < budget, 1);
  endtask

  initial begin
    int s0, c0, l0, d0;
    int e[$];
    reset_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_steps = 8'h00; step_period = '0;
    tick();
    fork compare_loop(); join_none
    tick();
    reset_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_cmd_ready", cmd_ready_d[0], 1);
    chk("rst_busy", busy_d[0], 0);
    chk("rst_dir", dir_d[0], 1);
    chk("rst_reg_data", reg_data_d[0], 0);
    chk("rst_coils_hold", coils_d[0], 0);

    // +3, period 2
    s0 = step_log.size(); c0 = coil_log.size(); l0 = loads;
    send(8'd3, 2);
    wait_end("t1", 100);
    e = '{4, 8, 12};   chk_log("t1_steps", step_log, s0, e);
    e = '{2, 4, 8};    chk_log("t1_coils", coil_log, c0, e);
    chk("t1_done_at", done_rel, 16);
    chk("t1_dir", dir_d[0], 1);
    chk("t1_reg_data", reg_data_d[0], 8'h03);
    chk("t1_loads", loads - l0, 1);

    // -2, period 0 treated as 1
    tick(); do_reset();
    s0 = step_log.size(); c0 = coil_log.size();
    send(8'hFE, 0);
    wait_end("t2", 100);
    e = '{4, 7};       chk_log("t2_steps", step_log, s0, e);
    e = '{8, 4};       chk_log("t2_coils", coil_log, c0, e);
    chk("t2_done_at", done_rel, 10);
    chk("t2_dir", dir_d[0], 0);

    // zero command
    s0 = step_log.size(); l0 = loads;
    send(8'd0, 5);
    wait_end("t3", 50);
    chk("t3_steps", step_log.size() - s0, 0);
    chk("t3_done_at", done_rel, 4);
    chk("t3_loads", loads - l0, 1);
    chk("t3_ready_in_done", cmd_ready_d[0], 0);
    @(negedge clk); #1;
    chk("t3_ready_after", cmd_ready_d[0], 1);

    // +5, abort in the cycle of the second step
    tick(); do_reset();
    s0 = step_log.size(); d0 = done_cnt;
    send(8'd5, 3);
    repeat (8) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk); #1;
    chk("t4_aborted", aborted_d[0], 1);
    repeat (3) tick();
    chk("t4_counter", cnt[0], 4);
    chk("t4_coils_hold", coils_d[0], 4'b0010);
    chk("t4_coils_nohold", coils_d[1], 4'b0000);
    e = '{4};          chk_log("t4_steps", step_log, s0, e);
    chk("t4_no_done", done_cnt - d0, 0);

    // reset in the middle of a dwell
    s0 = step_log.size(); d0 = done_cnt;
    send(8'd3, 5);
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk); #1;
    chk("t6_ready", cmd_ready_d[0], 1);
    chk("t6_coils_hold", coils_d[0], 0);
    chk("t6_aborted", aborted_d[0], 0);
    chk("t6_no_done", done_cnt - d0, 0);

    // -128 with cmd_valid held for the whole run
    s0 = step_log.size(); l0 = loads;
    tick();
    cmd_steps = 8'h80; step_period = '0; cmd_valid = 1'b1;
    wait_end("t5", 600);
    cmd_valid = 1'b0;
    chk("t5_steps", step_log.size() - s0, 128);
    chk("t5_loads", loads - l0, 1);
    chk("t5_done_at", done_rel, 388);
    tick();
    chk("t5_coils_nohold_idle", coils_d[1], 0);

    // randomized traffic against the model
    for (int c = 0; c < 6000; c++) begin
      tick();
      reset_n     = ($urandom_range(0, 499) != 0);
      cmd_valid   = ($urandom_range(0, 7) == 0);
      abort       = ($urandom_range(0, 59) == 0);
      cmd_steps   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'(int'($urandom_range(0, 12)) - 6);
      step_period = DW'($urandom_range(0, 3));
    end
    tick();
    reset_n = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
